// File: rtl/bomberman_draw_engine.sv
// Streams a background, 8x8 tile or transparent 8x8 sprite from memory into the VGA adapter.
// Latency: one address per cycle, plot 2 cycles after its address, finished 3 cycles after the last; copy_enable low aborts.
module bomberman_draw_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPR      = 8,
    parameter int COLOUR_W = 3,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = '0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                copy_enable,
    input  logic                draw_t,
    input  logic                draw_p1,
    input  logic                draw_p2,
    input  logic [4:0]          tile_col,
    input  logic [3:0]          tile_row,
    input  logic [1:0]          tile_id,
    input  logic [7:0]          p1_x,
    input  logic [7:0]          p2_x,
    input  logic [6:0]          p1_y,
    input  logic [6:0]          p2_y,
    output logic [14:0]         mem_addr,
    input  logic [COLOUR_W-1:0] mem_data,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                finished
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH1, S_FLUSH2, S_DONE} state_t;
    typedef enum logic [1:0] {M_BG, M_TILE, M_P1, M_P2} mode_t;

    state_t r_state, w_next;
    mode_t  r_mode, w_mode_in;

    logic [7:0]          r_org_x, w_org_x_in;
    logic [6:0]          r_org_y, w_org_y_in;
    logic [14:0]         r_base, w_base_in;
    logic [7:0]          r_cnt_x;
    logic [6:0]          r_cnt_y;
    logic                r_s1_vld;
    logic [8:0]          r_s1_x;
    logic [7:0]          r_s1_y;
    logic [7:0]          r_vga_x;
    logic [6:0]          r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_plot;

    logic [7:0]  w_wmax;
    logic [6:0]  w_hmax;
    logic        w_row_end;
    logic        w_last;
    logic        w_abort;
    logic        w_finished;
    logic [8:0]  w_dx;
    logic [7:0]  w_dy;
    logic [14:0] w_bg_addr;
    logic [14:0] w_spr_addr;
    logic        w_sprite;
    logic        w_onscreen;
    logic        w_opaque;

    // Mode priority and per-mode origin / sprite-sheet base, sampled only when leaving IDLE.
    always_comb begin
        w_mode_in  = M_BG;
        w_org_x_in = '0;
        w_org_y_in = '0;
        w_base_in  = '0;
        if (draw_t) begin
            w_mode_in  = M_TILE;
            w_org_x_in = 8'(tile_col) * 8'(SPR);
            w_org_y_in = 7'(tile_row) * 7'(SPR);
            w_base_in  = 15'(tile_id) * 15'(SPR * SPR);
        end else if (draw_p1) begin
            w_mode_in  = M_P1;
            w_org_x_in = p1_x;
            w_org_y_in = p1_y;
            w_base_in  = 15'(4 * SPR * SPR);
        end else if (draw_p2) begin
            w_mode_in  = M_P2;
            w_org_x_in = p2_x;
            w_org_y_in = p2_y;
            w_base_in  = 15'(5 * SPR * SPR);
        end
    end

    assign w_wmax    = (r_mode == M_BG) ? 8'(SCREEN_W - 1) : 8'(SPR - 1);
    assign w_hmax    = (r_mode == M_BG) ? 7'(SCREEN_H - 1) : 7'(SPR - 1);
    assign w_row_end = (r_cnt_x == w_wmax);
    assign w_last    = w_row_end && (r_cnt_y == w_hmax);
    assign w_abort   = !copy_enable &&
                       (r_state == S_RUN || r_state == S_FLUSH1 || r_state == S_FLUSH2);

    assign w_bg_addr  = 15'(r_cnt_y) * 15'(SCREEN_W) + 15'(r_cnt_x);
    assign w_spr_addr = r_base + 15'(r_cnt_y) * 15'(SPR) + 15'(r_cnt_x);
    assign mem_addr   = (r_state != S_RUN) ? '0 :
                        (r_mode == M_BG)   ? w_bg_addr : w_spr_addr;

    // Widened so that sprites hanging off the right/bottom edge clip instead of wrapping.
    assign w_dx = 9'(r_org_x) + 9'(r_cnt_x);
    assign w_dy = 8'(r_org_y) + 8'(r_cnt_y);

    assign w_sprite   = (r_mode == M_P1) || (r_mode == M_P2);
    assign w_onscreen = (r_s1_x < 9'(SCREEN_W)) && (r_s1_y < 8'(SCREEN_H));
    assign w_opaque   = !w_sprite || (mem_data != TRANSPARENT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_finished = 1'b0;
        case (r_state)
            S_IDLE:   if (copy_enable) w_next = S_RUN;
            S_RUN: begin
                if (!copy_enable) w_next = S_IDLE;
                else if (w_last)  w_next = S_FLUSH1;
            end
            S_FLUSH1: w_next = copy_enable ? S_FLUSH2 : S_IDLE;
            S_FLUSH2: w_next = copy_enable ? S_DONE : S_IDLE;
            S_DONE: begin
                w_finished = 1'b1;
                w_next     = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mode       <= M_BG;
            r_org_x      <= '0;
            r_org_y      <= '0;
            r_base       <= '0;
            r_cnt_x      <= '0;
            r_cnt_y      <= '0;
            r_s1_vld     <= 1'b0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && copy_enable) begin
                r_mode  <= w_mode_in;
                r_org_x <= w_org_x_in;
                r_org_y <= w_org_y_in;
                r_base  <= w_base_in;
                r_cnt_x <= '0;
                r_cnt_y <= '0;
            end else if (r_state == S_RUN && copy_enable) begin
                if (w_row_end) begin
                    r_cnt_x <= '0;
                    r_cnt_y <= r_cnt_y + 7'd1;
                end else begin
                    r_cnt_x <= r_cnt_x + 8'd1;
                end
            end

            // Stage 1 lines up with mem_data returned for the address issued this cycle.
            r_s1_vld <= (r_state == S_RUN) && copy_enable;
            r_s1_x   <= w_dx;
            r_s1_y   <= w_dy;

            r_vga_x      <= r_s1_x[7:0];
            r_vga_y      <= r_s1_y[6:0];
            r_vga_colour <= mem_data;
            r_vga_plot   <= !w_abort && r_s1_vld && w_onscreen && w_opaque;
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;
    assign finished   = w_finished;

endmodule
